// File: rtl/mw_pkg.sv
//------------------------------------------------------------------------------
// mw_pkg : shared types and constants for the microwave countdown timer
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package mw_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bcd_t c_max_digit    = 4'd9;
  localparam bcd_t c_max_sec_tens = 4'd5;

  function automatic logic is_bcd(input bcd_t d);
    return (d <= c_max_digit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mw_bcd_dec.sv
//------------------------------------------------------------------------------
// mw_bcd_dec : combinational MM:SS BCD decrement by one second, zero detect
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module mw_bcd_dec
  import mw_pkg::*;
(
  input  bcd_t i_min_tens,
  input  bcd_t i_min_ones,
  input  bcd_t i_sec_tens,
  input  bcd_t i_sec_ones,
  output bcd_t o_min_tens,
  output bcd_t o_min_ones,
  output bcd_t o_sec_tens,
  output bcd_t o_sec_ones,
  output logic o_zero
);

  logic w_borrow_so;
  logic w_borrow_st;
  logic w_borrow_mo;

  assign w_borrow_so = (i_sec_ones == 4'd0);
  assign w_borrow_st = w_borrow_so && (i_sec_tens == 4'd0);
  assign w_borrow_mo = w_borrow_st && (i_min_ones == 4'd0);

  // A borrow out of minutes always reloads sec_tens to 5, whatever was entered.
  assign o_sec_ones = w_borrow_so ? c_max_digit : (i_sec_ones - 4'd1);
  assign o_sec_tens = !w_borrow_so ? i_sec_tens :
                      (w_borrow_st ? c_max_sec_tens : (i_sec_tens - 4'd1));
  assign o_min_ones = !w_borrow_st ? i_min_ones :
                      (w_borrow_mo ? c_max_digit : (i_min_ones - 4'd1));
  assign o_min_tens = w_borrow_mo ? (i_min_tens - 4'd1) : i_min_tens;

  assign o_zero = (o_min_tens == 4'd0) && (o_min_ones == 4'd0) &&
                  (o_sec_tens == 4'd0) && (o_sec_ones == 4'd0);

endmodule

`default_nettype wire

// File: rtl/mw_timer.sv
//------------------------------------------------------------------------------
// mw_timer : MM:SS microwave countdown timer with keypad entry and FSM.
// Optional seconds normalisation on start: MW_TIMER_NORMALIZE_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mw_timer
  import mw_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       magnetron_on,
  output logic [1:0] state
);

  localparam int       c_b_loadn  = 0;
  localparam int       c_b_pgt    = 1;
  localparam int       c_b_startn = 2;
  localparam int       c_b_stopn  = 3;
  localparam int       c_b_clearn = 4;
  localparam int       c_b_door   = 5;
  localparam bcd_t     c_tps      = 4'(TICKS_PER_SEC);

  logic [5:0]      in_d, in_q, prev_q;
  bcd_t            din_d, din_q;
  logic [3:0][3:0] dig_d, dig_q;
  logic [3:0]      tick_cnt_d, tick_cnt_q;
  state_t          state_d, state_q;
  logic            magnetron_on_d, magnetron_on_q;

  logic            w_load_ev, w_tick, w_start_ev, w_stop_ev, w_clear_ev;
  logic            w_door, w_load_ok, w_zero, w_dec_zero;
  logic [3:0][3:0] w_dec, w_shift;
  logic [3:0]      w_cnt_inc;

  always_comb begin
    in_d  = {door_closed, clearn, stopn, startn, pgt_1Hz, loadn};
    din_d = D;
  end

  assign w_load_ev  = prev_q[c_b_loadn]  & ~in_q[c_b_loadn];
  assign w_tick     = ~prev_q[c_b_pgt]   &  in_q[c_b_pgt];
  assign w_start_ev = prev_q[c_b_startn] & ~in_q[c_b_startn];
  assign w_stop_ev  = prev_q[c_b_stopn]  & ~in_q[c_b_stopn];
  assign w_clear_ev = prev_q[c_b_clearn] & ~in_q[c_b_clearn];
  assign w_door     = in_q[c_b_door];

  assign w_load_ok = w_load_ev && is_bcd(din_q);
  assign w_zero    = (dig_q == '0);
  assign w_shift   = {dig_q[2:0], din_q};
  assign w_cnt_inc = tick_cnt_q + 4'd1;

  mw_bcd_dec u_dec (
    .i_min_tens (dig_q[3]),
    .i_min_ones (dig_q[2]),
    .i_sec_tens (dig_q[1]),
    .i_sec_ones (dig_q[0]),
    .o_min_tens (w_dec[3]),
    .o_min_ones (w_dec[2]),
    .o_sec_tens (w_dec[1]),
    .o_sec_ones (w_dec[0]),
    .o_zero     (w_dec_zero)
  );

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    tick_cnt_d = tick_cnt_q;

    if (w_clear_ev) begin
      dig_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // A concurrent stop outranks start; stop itself has no effect here.
          if (!w_stop_ev && w_start_ev && !w_zero && w_door) begin
            state_d    = RUN;
            tick_cnt_d = '0;
`ifdef MW_TIMER_NORMALIZE_EN
            if (dig_q[1] > c_max_sec_tens) begin
              if (dig_q[3] == c_max_digit && dig_q[2] == c_max_digit) begin
                dig_d = {c_max_digit, c_max_digit, c_max_sec_tens, c_max_digit};
              end else begin
                dig_d[1] = dig_q[1] - 4'd6;
                if (dig_q[2] == c_max_digit) begin
                  dig_d[3] = dig_q[3] + 4'd1;
                  dig_d[2] = 4'd0;
                end else begin
                  dig_d[2] = dig_q[2] + 4'd1;
                end
              end
            end
`endif
          end else if (!w_stop_ev && !w_start_ev && w_load_ok) begin
            dig_d = w_shift;
          end
        end
        RUN: begin
          if (w_stop_ev || !w_door) begin
            state_d = PAUSE;
          end else if (!w_start_ev && !w_load_ev && w_tick) begin
            if (w_cnt_inc >= c_tps) begin
              tick_cnt_d = '0;
              dig_d      = w_dec;
              if (w_dec_zero) state_d = DONE;
            end else begin
              tick_cnt_d = w_cnt_inc;
            end
          end
        end
        PAUSE: begin
          if (w_stop_ev) begin
            dig_d   = '0;
            state_d = IDLE;
          end else if (w_start_ev && w_door) begin
            state_d = RUN;
          end else if (!w_start_ev && w_load_ok) begin
            dig_d   = w_shift;
            state_d = IDLE;
          end
        end
        DONE: begin
          if (w_start_ev) begin
            state_d = IDLE;
          end else if (w_load_ev) begin
            state_d = IDLE;
            if (w_load_ok) dig_d = w_shift;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    magnetron_on_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q           <= '0;
      prev_q         <= '0;
      din_q          <= '0;
      dig_q          <= '0;
      tick_cnt_q     <= '0;
      state_q        <= IDLE;
      magnetron_on_q <= 1'b0;
    end else begin
      in_q           <= in_d;
      prev_q         <= in_q;
      din_q          <= din_d;
      dig_q          <= dig_d;
      tick_cnt_q     <= tick_cnt_d;
      state_q        <= state_d;
      magnetron_on_q <= magnetron_on_d;
    end
  end

  assign min_tens     = dig_q[3];
  assign min_ones     = dig_q[2];
  assign sec_tens     = dig_q[1];
  assign sec_ones     = dig_q[0];
  assign zero         = w_zero;
  assign magnetron_on = magnetron_on_q;
  assign state        = state_q;

endmodule

`default_nettype wire
